// File: rtl/hls_bus_pkg.sv
// Shared types for the two-master simple-bus arbiter and its read-order tracker.
package hls_bus_pkg;

  localparam int NUM_MASTERS = 2;
  // Payload struct widths; the arbiter's DATA_WIDTH / DATA_ADDR_WIDTH must not exceed these.
  localparam int CMD_ADDR_W = 32;
  localparam int CMD_DATA_W = 32;

  typedef logic master_id_t;

  typedef struct packed {
    logic [CMD_ADDR_W-1:0] address;
    logic [CMD_DATA_W-1:0] data;
    logic [3:0]            mask;
    logic                  write;
  } bus_cmd_t;

  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

endpackage

// File: rtl/hls_bus_arbiter_if.sv
// Simple-bus command/response port. The master side drives commands and receives
// responses; the slave side accepts commands and returns read data.
//
// Handshake: a command transfers on a cycle where cmd_valid and cmd_ready are both 1.
// Once cmd_valid is raised, the master holds it and the payload stable until that cycle.
// cmd_ready may depend combinationally on cmd_valid. rsp_valid is a one-cycle pulse
// with no back-pressure.
interface hls_bus_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_address;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic [3:0]            cmd_mask;
  logic                  cmd_write;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_address, cmd_data, cmd_mask, cmd_write,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_address, cmd_data, cmd_mask, cmd_write,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/hls_rsp_order_fifo.sv
// Records which master issued each outstanding read, in issue order.
// A push and a pop in the same cycle are allowed even when full.
module hls_rsp_order_fifo
  import hls_bus_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  master_id_t       push_id,
  input  logic             pop,
  output master_id_t       head_id,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  master_id_t       mem_q [DEPTH];
  master_id_t       mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign head_id = mem_q[rd_ptr_q];

  // When full, the pop frees the head slot that this push overwrites.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/hls_bus_arbiter.sv
// Round-robin arbiter sharing one simple-bus port between two masters, with
// in-order routing of read responses back to the issuing master.
module hls_bus_arbiter
  import hls_bus_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_ADDR_WIDTH = 32,
  parameter int MAX_OUTSTANDING = 4,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic             clk,
  input  logic             rst,
  hls_bus_if.slave         m0,
  hls_bus_if.slave         m1,
  hls_bus_if.master        s,
  output logic [CNT_W-1:0] outstanding,
  output logic             rsp_orphan,
  output lock_state_e      dbg_state
);

  lock_state_e state_q, state_d;
  master_id_t  lock_id_q, lock_id_d;
  master_id_t  prio_q, prio_d;
  logic        orphan_q, orphan_d;

  master_id_t  grant;
  bus_cmd_t    m0_cmd, m1_cmd, win_cmd;
  logic        win_valid, blocked, s_valid, accept, push, pop;
  logic        fifo_empty, fifo_full;
  master_id_t  head_id;

  always_comb begin
    m0_cmd = '{address: CMD_ADDR_W'(m0.cmd_address), data: CMD_DATA_W'(m0.cmd_data),
               mask: m0.cmd_mask, write: m0.cmd_write};
    m1_cmd = '{address: CMD_ADDR_W'(m1.cmd_address), data: CMD_DATA_W'(m1.cmd_data),
               mask: m1.cmd_mask, write: m1.cmd_write};
  end

  // A held (unaccepted) command keeps its grant so the payload cannot change under it.
  always_comb begin
    grant = prio_q;
    if (state_q == LOCK_HELD) begin
      grant = lock_id_q;
    end else if (m0.cmd_valid && !m1.cmd_valid) begin
      grant = 1'b0;
    end else if (m1.cmd_valid && !m0.cmd_valid) begin
      grant = 1'b1;
    end
  end

  assign win_cmd   = grant ? m1_cmd : m0_cmd;
  assign win_valid = grant ? m1.cmd_valid : m0.cmd_valid;

  // A read waits for a tracker slot rather than letting the other master overtake it.
  assign pop     = rst & s.rsp_valid & ~fifo_empty;
  assign blocked = ~win_cmd.write & fifo_full & ~pop;
  assign s_valid = rst & win_valid & ~blocked;
  assign accept  = s_valid & s.cmd_ready;
  assign push    = accept & ~win_cmd.write;

  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    prio_d    = prio_q;
    orphan_d  = orphan_q | (s.rsp_valid & fifo_empty);
    if (accept) begin
      state_d = LOCK_IDLE;
      prio_d  = ~grant;
    end else if (s_valid) begin
      state_d   = LOCK_HELD;
      lock_id_d = grant;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= LOCK_IDLE;
      lock_id_q <= 1'b0;
      prio_q    <= 1'b0;
      orphan_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      prio_q    <= prio_d;
      orphan_q  <= orphan_d;
    end
  end

  hls_rsp_order_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_order (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .push_id (grant),
    .pop     (pop),
    .head_id (head_id),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (outstanding)
  );

  assign s.cmd_valid   = s_valid;
  assign s.cmd_address = DATA_ADDR_WIDTH'(win_cmd.address);
  assign s.cmd_data    = DATA_WIDTH'(win_cmd.data);
  assign s.cmd_mask    = win_cmd.mask;
  assign s.cmd_write   = win_cmd.write;

  assign m0.cmd_ready = accept & (grant == 1'b0);
  assign m1.cmd_ready = accept & (grant == 1'b1);
  assign m0.rsp_valid = pop & (head_id == 1'b0);
  assign m1.rsp_valid = pop & (head_id == 1'b1);
  assign m0.rsp_data  = s.rsp_data;
  assign m1.rsp_data  = s.rsp_data;

  assign rsp_orphan = orphan_q;
  assign dbg_state  = state_q;

  a_locked_req_held: assert property (@(posedge clk) disable iff (!rst)
    (state_q == LOCK_HELD) |-> win_valid);

endmodule

// File: tb/tb_hls_bus_arbiter.sv
// Directed bench for hls_bus_arbiter: alternation, locking, read ordering, full
// tracker, orphan responses and reset mid-flight.
module tb_hls_bus_arbiter;
  import hls_bus_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MO = 4;
  localparam int CW = $clog2(MO) + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hls_bus_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m0_if ();
  hls_bus_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m1_if ();
  hls_bus_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s_if ();

  logic [CW-1:0] outstanding;
  logic          rsp_orphan;
  lock_state_e   dbg_state;

  hls_bus_arbiter #(
    .DATA_WIDTH      (DW),
    .DATA_ADDR_WIDTH (AW),
    .MAX_OUTSTANDING (MO)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .m0          (m0_if),
    .m1          (m1_if),
    .s           (s_if),
    .outstanding (outstanding),
    .rsp_orphan  (rsp_orphan),
    .dbg_state   (dbg_state)
  );

  // scoreboard
  int         n_vec  = 0;
  int         n_miss = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_m(input int idx, input logic v, input logic [31:0] addr, input logic wr);
    if (idx == 0) begin
      m0_if.cmd_valid = v; m0_if.cmd_address = addr; m0_if.cmd_data = addr ^ 32'hdead0000;
      m0_if.cmd_mask = 4'hf; m0_if.cmd_write = wr;
    end else begin
      m1_if.cmd_valid = v; m1_if.cmd_address = addr; m1_if.cmd_data = addr ^ 32'hbeef0000;
      m1_if.cmd_mask = 4'h3; m1_if.cmd_write = wr;
    end
  endtask

  task automatic idle_all();
    drive_m(0, 1'b0, 32'h0, 1'b1);
    drive_m(1, 1'b0, 32'h0, 1'b1);
    s_if.cmd_ready = 1'b0;
    s_if.rsp_valid = 1'b0;
    s_if.rsp_data  = '0;
  endtask

  task automatic check_cmd(input string tag, input logic sv, input logic r0, input logic r1,
                           input logic [31:0] addr);
    check({tag, ".s_valid"}, 64'(s_if.cmd_valid), 64'(sv));
    check({tag, ".m0_ready"}, 64'(m0_if.cmd_ready), 64'(r0));
    check({tag, ".m1_ready"}, 64'(m1_if.cmd_ready), 64'(r1));
    if (sv) check({tag, ".addr"}, 64'(s_if.cmd_address), 64'(addr));
  endtask

  task automatic check_rsp(input string tag, input logic v0, input logic v1, input logic [31:0] d);
    check({tag, ".m0_rsp_valid"}, 64'(m0_if.rsp_valid), 64'(v0));
    check({tag, ".m1_rsp_valid"}, 64'(m1_if.rsp_valid), 64'(v1));
    check({tag, ".m0_rsp_data"}, 64'(m0_if.rsp_data), 64'(d));
    check({tag, ".m1_rsp_data"}, 64'(m1_if.rsp_data), 64'(d));
  endtask

  // Single-master read issued with the port ready; recorded as expected response owner.
  task automatic issue_read(input string tag, input int idx, input logic [31:0] addr);
    idle_all();
    drive_m(idx, 1'b1, addr, 1'b0);
    s_if.cmd_ready = 1'b1;
    #1;
    check_cmd(tag, 1'b1, idx == 0, idx == 1, addr);
    exp_q.push_back(1'(idx));
    tick();
  endtask

  task automatic return_rsp(input string tag, input logic [31:0] d);
    logic [0:0] id;
    idle_all();
    s_if.rsp_valid = 1'b1;
    s_if.rsp_data  = d;
    #1;
    id = exp_q.pop_front();
    check_rsp(tag, id == 1'b0, id == 1'b1, d);
    tick();
  endtask

  initial begin
    idle_all();
    rst = 1'b0;
    tick();
    // outputs forced low while in reset, even with a request pending
    drive_m(0, 1'b1, 32'h40, 1'b1);
    s_if.cmd_ready = 1'b1;
    s_if.rsp_valid = 1'b1;
    #1;
    check_cmd("rst_gate", 1'b0, 1'b0, 1'b0, 32'h0);
    check_rsp("rst_gate", 1'b0, 1'b0, 32'h0);
    tick();
    idle_all();
    tick();
    rst = 1'b1;
    #1;
    check("rst.outstanding", 64'(outstanding), 64'd0);
    check("rst.orphan", 64'(rsp_orphan), 64'd0);
    check("rst.state", 64'(dbg_state), 64'(LOCK_IDLE));
    tick();

    // both masters stream writes: m0 first, then strict alternation
    for (int k = 0; k < 4; k++) begin
      idle_all();
      drive_m(0, 1'b1, 32'h1000 + 32'(k), 1'b1);
      drive_m(1, 1'b1, 32'h2000 + 32'(k), 1'b1);
      s_if.cmd_ready = 1'b1;
      #1;
      check_cmd($sformatf("alt%0d", k), 1'b1, (k % 2) == 0, (k % 2) == 1,
                ((k % 2) == 0) ? 32'h1000 + 32'(k) : 32'h2000 + 32'(k));
      check_rsp($sformatf("alt%0d", k), 1'b0, 1'b0, 32'h0);
      tick();
    end

    // m1 read stalled three cycles while m0 raises a write; grant stays on m1
    for (int k = 0; k < 4; k++) begin
      idle_all();
      drive_m(1, 1'b1, 32'h100, 1'b0);
      if (k > 0) drive_m(0, 1'b1, 32'h300, 1'b1);
      s_if.cmd_ready = (k == 3);
      #1;
      check_cmd($sformatf("lock%0d", k), 1'b1, 1'b0, k == 3, 32'h100);
      check($sformatf("lock%0d.write", k), 64'(s_if.cmd_write), 64'd0);
      if (k > 0) check($sformatf("lock%0d.state", k), 64'(dbg_state), 64'(LOCK_HELD));
      tick();
    end
    exp_q.push_back(1'b1);
    idle_all();
    drive_m(0, 1'b1, 32'h300, 1'b1);
    s_if.cmd_ready = 1'b1;
    #1;
    check_cmd("after_lock", 1'b1, 1'b1, 1'b0, 32'h300);
    check("after_lock.state", 64'(dbg_state), 64'(LOCK_IDLE));
    check("after_lock.outstanding", 64'(outstanding), 64'd1);
    tick();
    return_rsp("rsp_m1", 32'h55);

    // fill the tracker: m0,m1,m1,m0
    issue_read("rd0", 0, 32'h400);
    issue_read("rd1", 1, 32'h410);
    issue_read("rd2", 1, 32'h420);
    issue_read("rd3", 0, 32'h430);
    // prio now m1: its read blocks and m0's write must not slip past
    idle_all();
    drive_m(1, 1'b1, 32'h500, 1'b0);
    drive_m(0, 1'b1, 32'h600, 1'b1);
    s_if.cmd_ready = 1'b1;
    #1;
    check("full.outstanding", 64'(outstanding), 64'd4);
    check_cmd("full_block", 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    // response frees a slot in the same cycle the blocked read goes out
    s_if.rsp_valid = 1'b1;
    s_if.rsp_data  = 32'hA;
    #1;
    check_rsp("full_swap", 1'b1, 1'b0, 32'hA);
    check_cmd("full_swap", 1'b1, 1'b0, 1'b1, 32'h500);
    void'(exp_q.pop_front());
    exp_q.push_back(1'b1);
    tick();
    idle_all();
    #1;
    check("swap.outstanding", 64'(outstanding), 64'd4);
    tick();
    return_rsp("rspB", 32'hB);
    return_rsp("rspC", 32'hC);
    return_rsp("rspD", 32'hD);
    return_rsp("rspE", 32'hE);
    idle_all();
    #1;
    check("drain.outstanding", 64'(outstanding), 64'd0);
    check("drain.exp_q_empty", 64'(exp_q.size()), 64'd0);

    // orphan response
    s_if.rsp_valid = 1'b1;
    s_if.rsp_data  = 32'h77;
    #1;
    check_rsp("orphan", 1'b0, 1'b0, 32'h77);
    check("orphan.before", 64'(rsp_orphan), 64'd0);
    tick();
    idle_all();
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("orphan.sticky%0d", k), 64'(rsp_orphan), 64'd1);
      tick();
    end

    // reset with two reads in flight; last accept from m0 leaves prio on m1
    issue_read("pre_rst1", 1, 32'h700);
    issue_read("pre_rst0", 0, 32'h710);
    idle_all();
    #1;
    check("pre_rst.outstanding", 64'(outstanding), 64'd2);
    rst = 1'b0;
    tick();
    #1;
    check("in_rst.outstanding", 64'(outstanding), 64'd0);
    check("in_rst.orphan", 64'(rsp_orphan), 64'd0);
    tick();
    rst = 1'b1;
    exp_q.delete();
    drive_m(0, 1'b1, 32'h800, 1'b1);
    drive_m(1, 1'b1, 32'h900, 1'b1);
    s_if.cmd_ready = 1'b1;
    #1;
    check_cmd("post_rst_prio", 1'b1, 1'b1, 1'b0, 32'h800);
    tick();
    idle_all();
    s_if.rsp_valid = 1'b1;
    s_if.rsp_data  = 32'h99;
    #1;
    check_rsp("stale", 1'b0, 1'b0, 32'h99);
    tick();
    idle_all();
    #1;
    check("stale.orphan", 64'(rsp_orphan), 64'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
